// File: rtl/fwrisc_wb_arb_pkg.sv
// Shared types for the fwrisc two-to-one Wishbone arbiter.
package fwrisc_wb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        GNT_I,
        GNT_D
    } arb_state_e;

    typedef enum logic {
        REQ_I,
        REQ_D
    } arb_req_e;

endpackage

// File: rtl/fwrisc_wb_arb_wdog.sv
// Transfer watchdog: counts granted cycles without a response and flags expiry.
module fwrisc_wb_arb_wdog
    import fwrisc_wb_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic expire
);

    generate
        if (TIMEOUT == 0) begin : g_off
            logic unused_in;
            assign unused_in = ^{clock, reset, clear, run};
            assign expire    = 1'b0;
        end else begin : g_on
            localparam int unsigned CW = $clog2(TIMEOUT + 1);
            localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

            logic [CW-1:0] cnt_q;

            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    cnt_q <= '0;
                end else if (clear) begin
                    cnt_q <= '0;
                end else if (run) begin
                    cnt_q <= cnt_q + CW'(1);
                end
            end

            // Ungated by ack/err so the bus gate never sees a target response.
            assign expire = (cnt_q == LIMIT);
        end
    endgenerate

endmodule

// File: rtl/fwrisc_wb_arb2.sv
// Two-to-one Wishbone arbiter sharing one initiator port between the fwrisc
// instruction and data ports, with alternating priority and a watchdog.
module fwrisc_wb_arb2
    import fwrisc_wb_arb_pkg::*;
#(
    parameter int unsigned ADR_WIDTH = 32,
    parameter int unsigned DAT_WIDTH = 32,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic                   clock,
    input  logic                   reset,

    input  logic [ADR_WIDTH-1:0]   wbi_adr,
    input  logic [DAT_WIDTH-1:0]   wbi_dat_w,
    input  logic [DAT_WIDTH/8-1:0] wbi_sel,
    input  logic                   wbi_we,
    input  logic                   wbi_cyc,
    input  logic                   wbi_stb,
    output logic [DAT_WIDTH-1:0]   wbi_dat_r,
    output logic                   wbi_ack,
    output logic                   wbi_err,

    input  logic [ADR_WIDTH-1:0]   wbd_adr,
    input  logic [DAT_WIDTH-1:0]   wbd_dat_w,
    input  logic [DAT_WIDTH/8-1:0] wbd_sel,
    input  logic                   wbd_we,
    input  logic                   wbd_cyc,
    input  logic                   wbd_stb,
    output logic [DAT_WIDTH-1:0]   wbd_dat_r,
    output logic                   wbd_ack,
    output logic                   wbd_err,

    output logic [ADR_WIDTH-1:0]   wbt_adr,
    output logic [DAT_WIDTH-1:0]   wbt_dat_w,
    output logic [DAT_WIDTH/8-1:0] wbt_sel,
    output logic                   wbt_we,
    output logic                   wbt_cyc,
    output logic                   wbt_stb,
    input  logic [DAT_WIDTH-1:0]   wbt_dat_r,
    input  logic                   wbt_ack,
    input  logic                   wbt_err,

    output logic                   timeout_evt
);

    arb_state_e state_q, state_d;
    arb_req_e   last_gnt_q, last_gnt_d;
    logic       req_i, req_d, in_gnt, wd_expire, kill;

    assign req_i  = wbi_cyc & wbi_stb;
    assign req_d  = wbd_cyc & wbd_stb;
    assign in_gnt = (state_q != IDLE);
    assign kill   = in_gnt & wd_expire;

    fwrisc_wb_arb_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clock  (clock),
        .reset  (reset),
        .clear  (state_q == IDLE),
        .run    (in_gnt & ~wbt_ack & ~wbt_err),
        .expire (wd_expire)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            last_gnt_q <= REQ_D;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        unique case (state_q)
            IDLE: begin
                // I wins when alone, or under contention if D was served last.
                if (req_i && (!req_d || last_gnt_q == REQ_D)) begin
                    state_d    = GNT_I;
                    last_gnt_d = REQ_I;
                end else if (req_d) begin
                    state_d    = GNT_D;
                    last_gnt_d = REQ_D;
                end
            end
            GNT_I: if (wbt_ack || wbt_err || kill || !wbi_cyc) state_d = IDLE;
            GNT_D: if (wbt_ack || wbt_err || kill || !wbd_cyc) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wbt_adr     = '0;
        wbt_dat_w   = '0;
        wbt_sel     = '0;
        wbt_we      = 1'b0;
        wbt_cyc     = 1'b0;
        wbt_stb     = 1'b0;
        wbi_ack     = 1'b0;
        wbi_err     = 1'b0;
        wbd_ack     = 1'b0;
        wbd_err     = 1'b0;
        timeout_evt = 1'b0;
        unique case (state_q)
            GNT_I: begin
                wbt_adr     = wbi_adr;
                wbt_dat_w   = wbi_dat_w;
                wbt_sel     = wbi_sel;
                wbt_we      = wbi_we;
                wbt_cyc     = wbi_cyc & ~kill;
                wbt_stb     = wbi_stb & ~kill;
                wbi_ack     = wbt_ack;
                wbi_err     = wbt_err | (kill & ~wbt_ack);
                timeout_evt = kill & ~wbt_ack & ~wbt_err;
            end
            GNT_D: begin
                wbt_adr     = wbd_adr;
                wbt_dat_w   = wbd_dat_w;
                wbt_sel     = wbd_sel;
                wbt_we      = wbd_we;
                wbt_cyc     = wbd_cyc & ~kill;
                wbt_stb     = wbd_stb & ~kill;
                wbd_ack     = wbt_ack;
                wbd_err     = wbt_err | (kill & ~wbt_ack);
                timeout_evt = kill & ~wbt_ack & ~wbt_err;
            end
            default: ;
        endcase
    end

    assign wbi_dat_r = wbt_dat_r;
    assign wbd_dat_r = wbt_dat_r;

endmodule

// File: tb/tb_fwrisc_wb_arb2.sv
// Self-checking bench for fwrisc_wb_arb2: directed cycle table plus randomized
// traffic checked against a transaction-level arbiter model.
module tb_fwrisc_wb_arb2;

    localparam int TO = 4;
    localparam logic [31:0] I_ADR = 32'h0000_0100;
    localparam logic [31:0] I_DAT = 32'h1111_2222;
    localparam logic [3:0]  I_SEL = 4'hF;
    localparam logic        I_WE  = 1'b0;
    localparam logic [31:0] D_ADR = 32'h0000_2000;
    localparam logic [31:0] D_DAT = 32'hDEAD_BEEF;
    localparam logic [3:0]  D_SEL = 4'hF;
    localparam logic        D_WE  = 1'b1;

    logic        clock, reset;
    logic [31:0] q_adr [2];
    logic [31:0] q_dat [2];
    logic [3:0]  q_sel [2];
    logic        q_we  [2];
    logic        q_cyc [2];
    logic        q_stb [2];
    logic [31:0] tdr;
    logic        tack, terr;

    logic [31:0] wbi_dat_r, wbd_dat_r, wbt_adr, wbt_dat_w;
    logic [3:0]  wbt_sel;
    logic        wbi_ack, wbi_err, wbd_ack, wbd_err;
    logic        wbt_we, wbt_cyc, wbt_stb, timeout_evt;

    fwrisc_wb_arb2 #(
        .ADR_WIDTH (32),
        .DAT_WIDTH (32),
        .TIMEOUT   (TO)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .wbi_adr     (q_adr[0]),
        .wbi_dat_w   (q_dat[0]),
        .wbi_sel     (q_sel[0]),
        .wbi_we      (q_we[0]),
        .wbi_cyc     (q_cyc[0]),
        .wbi_stb     (q_stb[0]),
        .wbi_dat_r   (wbi_dat_r),
        .wbi_ack     (wbi_ack),
        .wbi_err     (wbi_err),
        .wbd_adr     (q_adr[1]),
        .wbd_dat_w   (q_dat[1]),
        .wbd_sel     (q_sel[1]),
        .wbd_we      (q_we[1]),
        .wbd_cyc     (q_cyc[1]),
        .wbd_stb     (q_stb[1]),
        .wbd_dat_r   (wbd_dat_r),
        .wbd_ack     (wbd_ack),
        .wbd_err     (wbd_err),
        .wbt_adr     (wbt_adr),
        .wbt_dat_w   (wbt_dat_w),
        .wbt_sel     (wbt_sel),
        .wbt_we      (wbt_we),
        .wbt_cyc     (wbt_cyc),
        .wbt_stb     (wbt_stb),
        .wbt_dat_r   (tdr),
        .wbt_ack     (tack),
        .wbt_err     (terr),
        .timeout_evt (timeout_evt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [127:0] pack_bus(logic [31:0] adr, logic [31:0] dat, logic [3:0] sel,
                                              logic we, logic cyc, logic stb);
        return {57'b0, adr, dat, sel, we, cyc, stb};
    endfunction

    task automatic check_outputs(input string tag, input logic [127:0] e_bus,
                                 input logic [4:0] e_resp);
        check({tag, ".bus"}, pack_bus(wbt_adr, wbt_dat_w, wbt_sel, wbt_we, wbt_cyc, wbt_stb), e_bus);
        check({tag, ".resp"}, {123'b0, wbi_ack, wbi_err, wbd_ack, wbd_err, timeout_evt},
              {123'b0, e_resp});
        check({tag, ".dat_r"}, {64'b0, wbi_dat_r, wbd_dat_r}, {64'b0, tdr, tdr});
    endtask

    // src: 0 = no grant, 1 = I granted, 2 = D granted
    typedef struct {
        bit rst_n, ic, dc, ack, err;
        int src;
        bit cyc, ia, ie, da, de, evt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit rst_n, bit ic, bit dc, bit ack, bit err, int src,
                                bit cyc, bit ia, bit ie, bit da, bit de, bit evt);
        vec_t v;
        v.rst_n = rst_n; v.ic = ic; v.dc = dc; v.ack = ack; v.err = err; v.src = src;
        v.cyc = cyc; v.ia = ia; v.ie = ie; v.da = da; v.de = de; v.evt = evt;
        return v;
    endfunction

    // Randomized-phase model state
    int  m_owner, m_age, m_last;
    bit  act [2];

    initial begin
        logic [127:0] e_bus;
        reset = 1'b0;
        for (int x = 0; x < 2; x++) begin
            q_cyc[x] = 1'b0; q_stb[x] = 1'b0;
        end
        q_adr[0] = I_ADR; q_dat[0] = I_DAT; q_sel[0] = I_SEL; q_we[0] = I_WE;
        q_adr[1] = D_ADR; q_dat[1] = D_DAT; q_sel[1] = D_SEL; q_we[1] = D_WE;
        tack = 1'b0; terr = 1'b0; tdr = '0;

        //                rst ic dc ak er src cyc ia ie da de evt
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0)); // in reset, ack ignored
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); // I fetch seen at N
        tbl.push_back(mk(1, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0)); // N+1 granted
        tbl.push_back(mk(1, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 1, 0, 1, 1, 1, 0, 0, 0, 0)); // N+3 ack
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); // reset before contention
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0)); // contention
        tbl.push_back(mk(1, 1, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0)); // I first
        tbl.push_back(mk(1, 1, 1, 1, 0, 1, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 1, 0, 2, 1, 0, 0, 1, 0, 0)); // D 2 cycles after I ack
        tbl.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0)); // contention again
        tbl.push_back(mk(1, 1, 1, 1, 0, 1, 1, 1, 0, 0, 0, 0)); // alternates back to I
        tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 0, 0, 2, 1, 0, 0, 0, 0, 0)); // D write, grant G
        tbl.push_back(mk(1, 0, 1, 0, 0, 2, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 0, 0, 2, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 0, 0, 2, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 0, 0, 2, 0, 0, 0, 0, 1, 1)); // G+4 watchdog
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 0, 0, 2, 1, 0, 0, 0, 0, 0)); // grant G
        tbl.push_back(mk(1, 0, 1, 0, 0, 2, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 0, 0, 2, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 0, 0, 2, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 1, 0, 2, 0, 0, 0, 1, 0, 0)); // ack in expiry cycle
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0)); // I granted
        tbl.push_back(mk(1, 0, 1, 1, 0, 1, 0, 1, 0, 0, 0, 0)); // abort, late ack forwarded
        tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 0, 0, 2, 1, 0, 0, 0, 0, 0)); // pending D granted
        tbl.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0)); // reset mid GNT_D
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0)); // normal latency
        tbl.push_back(mk(1, 1, 0, 1, 1, 1, 1, 1, 1, 0, 0, 0)); // ack+err forwarded
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        for (int k = 0; k < tbl.size(); k++) begin
            @(negedge clock);
            reset    = tbl[k].rst_n;
            q_cyc[0] = tbl[k].ic; q_stb[0] = tbl[k].ic;
            q_cyc[1] = tbl[k].dc; q_stb[1] = tbl[k].dc;
            tack     = tbl[k].ack;
            terr     = tbl[k].err;
            tdr      = $urandom;
            #1;
            case (tbl[k].src)
                1:       e_bus = pack_bus(I_ADR, I_DAT, I_SEL, I_WE, tbl[k].cyc, tbl[k].cyc);
                2:       e_bus = pack_bus(D_ADR, D_DAT, D_SEL, D_WE, tbl[k].cyc, tbl[k].cyc);
                default: e_bus = '0;
            endcase
            check_outputs($sformatf("vec%0d", k), e_bus,
                          {tbl[k].ia, tbl[k].ie, tbl[k].da, tbl[k].de, tbl[k].evt});
        end

        // Randomized traffic against the model
        @(negedge clock);
        reset = 1'b0;
        for (int x = 0; x < 2; x++) begin
            act[x] = 1'b0; q_cyc[x] = 1'b0; q_stb[x] = 1'b0;
        end
        tack = 1'b0; terr = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        m_owner = 0; m_age = 0; m_last = 2;

        for (int c = 0; c < 3000; c++) begin
            bit expired, r_i, r_d;
            int xi, nxt;
            logic [4:0] e_resp;
            bit e_ack [2];
            bit e_err [2];
            bit e_evt;
            @(negedge clock);
            for (int x = 0; x < 2; x++) begin
                if (!act[x] && $urandom_range(2) == 0) begin
                    act[x]   = 1'b1;
                    q_adr[x] = $urandom;
                    q_dat[x] = $urandom;
                    q_sel[x] = 4'($urandom_range(15));
                    q_we[x]  = 1'($urandom_range(1));
                end else if (act[x] && $urandom_range(39) == 0) begin
                    act[x] = 1'b0;
                end
                q_cyc[x] = act[x];
                q_stb[x] = act[x];
            end
            tack = ($urandom_range(3) == 0);
            terr = ($urandom_range(11) == 0);
            tdr  = $urandom;
            #1;

            e_bus = '0;
            e_ack[0] = 0; e_ack[1] = 0; e_err[0] = 0; e_err[1] = 0; e_evt = 0;
            expired = (m_owner != 0) && (m_age == TO);
            if (m_owner != 0) begin
                xi = m_owner - 1;
                e_bus = pack_bus(q_adr[xi], q_dat[xi], q_sel[xi], q_we[xi],
                                 q_cyc[xi] & ~expired, q_stb[xi] & ~expired);
                e_ack[xi] = tack;
                e_err[xi] = terr | (expired & ~tack);
                e_evt     = expired & ~tack & ~terr;
            end
            e_resp = {e_ack[0], e_err[0], e_ack[1], e_err[1], e_evt};
            check_outputs($sformatf("rnd%0d", c), e_bus, e_resp);

            for (int x = 0; x < 2; x++)
                if (act[x] && (e_ack[x] || e_err[x])) act[x] = 1'b0;

            if (m_owner == 0) begin
                r_i = q_cyc[0] & q_stb[0];
                r_d = q_cyc[1] & q_stb[1];
                if (r_i && r_d) nxt = (m_last == 2) ? 1 : 2;
                else if (r_i)   nxt = 1;
                else if (r_d)   nxt = 2;
                else            nxt = 0;
                if (nxt != 0) begin
                    m_owner = nxt; m_last = nxt; m_age = 0;
                end
            end else begin
                xi = m_owner - 1;
                if (tack || terr || expired || !q_cyc[xi]) m_owner = 0;
                else m_age++;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
